// File: rtl/pipe_adder_pkg.sv
// Shared types and defaults for the pipelined adder/subtractor.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Subtraction is A + ~B + ~borrow, so the borrow-in is inverted into a carry-in.
  function automatic logic eff_cin(input op_e op, input logic cin);
    return (op == OP_SUB) ? ~cin : cin;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline slot: sums operand chunk IDX with the incoming carry and registers the result.
// Loads on i_ld; payload only updates when a valid transaction enters, so outputs hold otherwise.
module pipe_adder_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cin,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic             r_vld;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_sum_nxt;

  assign w_chunk = {1'b0, i_a[IDX*CHUNK +: CHUNK]}
                 + {1'b0, i_b[IDX*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, i_cin};

  always_comb begin
    w_sum_nxt = i_sum;
    w_sum_nxt[IDX*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      if (i_ld) begin
        r_vld <= i_vld;
      end
      if (i_ld && i_vld) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_sum   <= w_sum_nxt;
        r_carry <= w_chunk[CHUNK];
      end
    end
  end

  assign o_vld   = r_vld;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;

endmodule

// File: rtl/pipe_adder.sv
// Chunked ripple adder/subtractor, STAGES slots deep, one result per cycle.
// in_ready is combinational from out_ready through the per-stage load chain (bubbles collapse).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  op_e              Op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CHUNK = WIDTH / ((STAGES < 1) ? 1 : STAGES);

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("pipe_adder: STAGES must be at least 1");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
      $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // Index k is the input of stage k; index k+1 is its registered output.
  logic             w_vld [STAGES+1];
  logic             w_ld  [STAGES+1];
  logic [WIDTH-1:0] w_a   [STAGES+1];
  logic [WIDTH-1:0] w_b   [STAGES+1];
  logic [WIDTH-1:0] w_sum [STAGES+1];
  logic             w_cy  [STAGES+1];

  assign w_vld[0] = in_valid;
  assign w_a[0]   = A;
  assign w_b[0]   = (Op == OP_SUB) ? ~B : B;
  assign w_sum[0] = '0;
  assign w_cy[0]  = eff_cin(Op, C_in);

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    w_ld[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ld[k] = !w_vld[k+1] || w_ld[k+1];
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_adder_stage #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .IDX   (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ld    (w_ld[k]),
        .i_vld   (w_vld[k]),
        .i_a     (w_a[k]),
        .i_b     (w_b[k]),
        .i_sum   (w_sum[k]),
        .i_cin   (w_cy[k]),
        .o_vld   (w_vld[k+1]),
        .o_a     (w_a[k+1]),
        .o_b     (w_b[k+1]),
        .o_sum   (w_sum[k+1]),
        .o_carry (w_cy[k+1])
      );
    end
  endgenerate

  assign in_ready  = w_ld[0];
  assign out_valid = w_vld[STAGES];
  assign Sum       = w_sum[STAGES];
  assign C_out     = w_cy[STAGES];
  assign Overflow  = (w_a[STAGES][WIDTH-1] == w_b[STAGES][WIDTH-1]) &&
                     (w_sum[STAGES][WIDTH-1] != w_a[STAGES][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder at WIDTH=16, STAGES=4.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  op_e         Op;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Sum;
  logic        C_out;
  logic        Overflow;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    op_e         op;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt[8];

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .C_in      (C_in),
    .Op        (Op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sum       (Sum),
    .C_out     (C_out),
    .Overflow  (Overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] s, input logic co, input logic ov);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".sum"},   {16'd0, Sum},       {16'd0, s});
    check({tag, ".cout"},  {31'd0, C_out},     {31'd0, co});
    check({tag, ".ovf"},   {31'd0, Overflow},  {31'd0, ov});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input op_e o, input logic [15:0] a,
                       input logic [15:0] b, input logic c);
    in_valid = v;
    Op       = o;
    A        = a;
    B        = b;
    C_in     = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    int k;
    logic [15:0] rel_exp[4];

    vt[0] = '{OP_ADD, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vt[1] = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[3] = '{OP_SUB, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b1, 1'b0};
    vt[4] = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{OP_ADD, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};
    vt[6] = '{OP_SUB, 16'h0005, 16'h0007, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vt[7] = '{OP_ADD, 16'h0FFF, 16'hF001, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
    #2;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.sum",       {16'd0, Sum},       32'd0);
    check("rst.cout",      {31'd0, C_out},     32'd0);
    check("rst.ovf",       {31'd0, Overflow},  32'd0);
    check("rst.in_ready",  {31'd0, in_ready},  32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Single transaction: carry ripples through every chunk, valid after the 4th edge.
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    #1;
    check("single.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("single.lat%0d", s), {31'd0, out_valid}, 32'd0);
      tick();
    end
    check("single.lat2", {31'd0, out_valid}, 32'd0);
    tick();
    check_res("single", 16'h0000, 1'b1, 1'b0);
    tick();
    check("single.drained", {31'd0, out_valid}, 32'd0);
    check("single.hold_sum", {16'd0, Sum}, 32'h0000);
    check("single.hold_cout", {31'd0, C_out}, 32'd1);

    // Eight back-to-back accepts, one result per cycle in order.
    for (int s = 0; s < 12; s++) begin
      if (s < 8) drive(1'b1, vt[s].op, vt[s].a, vt[s].b, vt[s].c);
      else in_valid = 1'b0;
      #1;
      if (s < 8) check($sformatf("b2b.in_ready%0d", s), {31'd0, in_ready}, 32'd1);
      tick();
      if (s >= 3 && s <= 10)
        check_res($sformatf("b2b.res%0d", s - 3), vt[s-3].s, vt[s-3].co, vt[s-3].ov);
      else
        check($sformatf("b2b.idle%0d", s), {31'd0, out_valid}, 32'd0);
    end

    // Stall: out_ready low, in_valid held high for ten cycles.
    out_ready = 1'b0;
    accepted  = 0;
    k         = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, OP_ADD, 16'h1000 + 16'(k), 16'h0100, 1'b0);
      #1;
      if (in_ready) begin
        accepted++;
        k++;
      end
      tick();
      if (c >= 3) begin
        check($sformatf("stall.valid%0d", c), {31'd0, out_valid}, 32'd1);
        check($sformatf("stall.sum%0d", c),   {16'd0, Sum},       32'h1100);
      end
    end
    check("stall.accepted", accepted, 4);
    check("stall.in_ready", {31'd0, in_ready}, 32'd0);

    // Release with a new input: full pipeline accepts and drains in the same cycle.
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 16'h2000, 16'h0000, 1'b0);
    #1;
    check("release.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    rel_exp[0] = 16'h1101;
    rel_exp[1] = 16'h1102;
    rel_exp[2] = 16'h1103;
    rel_exp[3] = 16'h2000;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("release.valid%0d", j), {31'd0, out_valid}, 32'd1);
      check($sformatf("release.sum%0d", j),   {16'd0, Sum},       {16'd0, rel_exp[j]});
      tick();
    end
    check("release.empty", {31'd0, out_valid}, 32'd0);
    check("release.hold",  {16'd0, Sum},       32'h2000);

    // Reset with three transactions in flight.
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, OP_ADD, 16'h8000, 16'h8001, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_res("inflight", 16'h0001, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst.sum",       {16'd0, Sum},       32'd0);
    check("midrst.cout",      {31'd0, C_out},     32'd0);
    check("midrst.ovf",       {31'd0, Overflow},  32'd0);
    check("midrst.in_ready",  {31'd0, in_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("midrst.no_stale%0d", s), {31'd0, out_valid}, 32'd0);
    end
    drive(1'b1, OP_ADD, 16'h0003, 16'h0004, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("postrst.lat", {31'd0, out_valid}, 32'd0);
    tick();
    check_res("postrst", 16'h0007, 1'b0, 1'b0);
    tick();
    check("postrst.empty", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
